// File: rtl/sobel_stream_ctrl_if.sv
// ---------------------------------------------------------------------------
// sobel_stream_ctrl_if
// Pixel-in / edge-out stream bundle for sobel_stream_ctrl.
//
// Handshake rule for both directions: a transfer happens on a rising clock
// edge where valid and ready are both 1. A producer holding valid=1 keeps
// its payload stable until that transfer; ready may depend on valid
// combinationally, valid never depends on ready.
//
// Signals
//   in_valid  / in_ready  / in_pixel[7:0] : pixel stream, raster order
//   out_valid / out_ready / out_edge      : edge-bit stream, interior pixels
// Modports
//   master : pixel source + edge sink side (drives in_*, out_ready)
//   slave  : the controller (drives in_ready, out_valid, out_edge)
// ---------------------------------------------------------------------------
interface sobel_stream_ctrl_if;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_pixel;
  logic       out_valid;
  logic       out_ready;
  logic       out_edge;

  modport master (
    output in_valid, in_pixel, out_ready,
    input  in_ready, out_valid, out_edge
  );

  modport slave (
    input  in_valid, in_pixel, out_ready,
    output in_ready, out_valid, out_edge
  );
endinterface

// File: rtl/sobel_stream_ctrl.sv
// ---------------------------------------------------------------------------
// sobel_stream_ctrl
// Streams a raster-scan 8-bit image through a Sobel edge operator. Two line
// buffers plus a 3x3 window feed the operator; one registered edge bit is
// emitted per interior pixel (row >= 2 and col >= 2).
//
// Parameters : IMG_W, IMG_H (image size, both >= 3)
// Ports
//   clk, rst_n     : clock (rising edge), asynchronous active-low reset
//   start          : begins a frame when in IDLE; threshold latched then
//   threshold[7:0] : edge threshold, edge = (|gx|+|gy|) > threshold
//   stream         : sobel_stream_ctrl_if.slave (pixel in, edge out)
//   busy           : high while in RUN or DRAIN
//   done           : one-cycle pulse on the cycle the FSM re-enters IDLE
//   edge_count     : edges counted in the last frame
//   dbg_state      : current FSM state (0 IDLE, 1 RUN, 2 DRAIN)
// Optional feature macro: SOBEL_EDGE_COUNT_EN enables the edge counter;
// when undefined edge_count is tied to 0.
// ---------------------------------------------------------------------------
module sobel_stream_ctrl #(
  parameter int IMG_W = 64,
  parameter int IMG_H = 64
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic [7:0]                    threshold,
  sobel_stream_ctrl_if.slave            stream,
  output logic                          busy,
  output logic                          done,
  output logic [$clog2(IMG_W*IMG_H):0]  edge_count,
  output logic [1:0]                    dbg_state
);
  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam int EW = $clog2(IMG_W*IMG_H) + 1;
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] col_q;
  logic [RW-1:0] row_q;
  logic [7:0]    thr_q;
  logic          in_ready, out_valid_q, out_edge_q;
  logic          accept, start_acc, out_fire, interior, last_px;

  // win_q[row][col]: row 0 = oldest line, col 2 = newest column.
  logic [7:0] win_q [3][3];
  logic [7:0] win_d [3][3];
  logic [7:0] lb0 [IMG_W];
  logic [7:0] lb1 [IMG_W];

  assign stream.in_ready  = in_ready;
  assign stream.out_valid = out_valid_q;
  assign stream.out_edge  = out_edge_q;

  assign accept    = stream.in_valid && in_ready;
  assign start_acc = start && (state_q == IDLE);
  assign out_fire  = out_valid_q && stream.out_ready;
  assign interior  = (row_q >= RW'(2)) && (col_q >= CW'(2));
  assign last_px   = (row_q == ROW_LAST) && (col_q == COL_LAST);

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (accept && last_px) state_d = DRAIN;
      DRAIN:   if (!out_valid_q || stream.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    in_ready  = (state_q == RUN) && (!out_valid_q || stream.out_ready);
    busy      = (state_q != IDLE);
    dbg_state = state_q;
  end

  // Post-shift window: what the window becomes if the current pixel is taken.
  // The core sees this so the edge bit lines up with the accepted pixel.
  always_comb begin
    for (int r = 0; r < 3; r++) begin
      win_d[r][0] = win_q[r][1];
      win_d[r][1] = win_q[r][2];
    end
    win_d[0][2] = lb0[col_q];
    win_d[1][2] = lb1[col_q];
    win_d[2][2] = stream.in_pixel;
  end

  // ---------------- Sobel core ----------------
  function automatic logic [9:0] x1(input logic [7:0] v);
    return {2'b00, v};
  endfunction

  function automatic logic [9:0] x2(input logic [7:0] v);
    return {1'b0, v, 1'b0};
  endfunction

  logic [9:0]  gx_pos, gx_neg, gy_pos, gy_neg, gx_abs, gy_abs;
  logic [11:0] grad;
  logic        core_edge;

  // Each partial sum is at most 4*255 = 1020, so 10 bits never overflow;
  // magnitudes are taken as the difference of the two non-negative halves.
  always_comb begin
    gx_pos    = x1(win_d[0][2]) + x2(win_d[1][2]) + x1(win_d[2][2]);
    gx_neg    = x1(win_d[0][0]) + x2(win_d[1][0]) + x1(win_d[2][0]);
    gy_pos    = x1(win_d[2][0]) + x2(win_d[2][1]) + x1(win_d[2][2]);
    gy_neg    = x1(win_d[0][0]) + x2(win_d[0][1]) + x1(win_d[0][2]);
    gx_abs    = (gx_pos >= gx_neg) ? (gx_pos - gx_neg) : (gx_neg - gx_pos);
    gy_abs    = (gy_pos >= gy_neg) ? (gy_pos - gy_neg) : (gy_neg - gy_pos);
    grad      = {2'b00, gx_abs} + {2'b00, gy_abs};
    core_edge = grad > {4'b0000, thr_q};
  end

  // ---------------- Datapath ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q       <= '0;
      row_q       <= '0;
      thr_q       <= '0;
      out_valid_q <= 1'b0;
      out_edge_q  <= 1'b0;
      done        <= 1'b0;
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 3; c++)
          win_q[r][c] <= '0;
    end else begin
      done <= (state_q == DRAIN) && (state_d == IDLE);
      if (start_acc) begin
        col_q <= '0;
        row_q <= '0;
        thr_q <= threshold;
        for (int r = 0; r < 3; r++)
          for (int c = 0; c < 3; c++)
            win_q[r][c] <= '0;
      end else if (accept) begin
        win_q <= win_d;
        // The window is not cleared on wrap; its stale columns only reach
        // the core for col < 2, which never produces an output.
        if (col_q == COL_LAST) begin
          col_q <= '0;
          row_q <= row_q + 1'b1;
        end else begin
          col_q <= col_q + 1'b1;
        end
      end
      // An accept while out_valid is set implies out_ready (see in_ready),
      // so overwriting the held bit here never drops an output.
      if (accept && interior) begin
        out_valid_q <= 1'b1;
        out_edge_q  <= core_edge;
      end else if (out_fire) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  // Line buffers hold no reset: rows 0 and 1 are never emitted, so whatever
  // they hold before being written cannot reach an output.
  always_ff @(posedge clk) begin
    if (accept) begin
      lb0[col_q] <= lb1[col_q];
      lb1[col_q] <= stream.in_pixel;
    end
  end

`ifdef SOBEL_EDGE_COUNT_EN
  logic [EW-1:0] cnt_q, cnt_d, edge_count_q;

  always_comb begin
    cnt_d = cnt_q;
    if (out_fire && out_edge_q) cnt_d = cnt_q + 1'b1;
  end

  // The frame total is captured with cnt_d so a final output accepted on
  // the DRAIN exit cycle is still included.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q        <= '0;
      edge_count_q <= '0;
    end else begin
      if (start_acc) cnt_q <= '0;
      else           cnt_q <= cnt_d;
      if ((state_q == DRAIN) && (state_d == IDLE)) edge_count_q <= cnt_d;
    end
  end

  assign edge_count = edge_count_q;
`else
  assign edge_count = '0;
`endif

endmodule

// File: tb/tb_sobel_stream_ctrl.sv
// ---------------------------------------------------------------------------
// tb_sobel_stream_ctrl
// Drives 8x8 frames (directed and random) into sobel_stream_ctrl with
// optional random in_valid / out_ready stalls. Expected edge bits come from
// a direct Sobel evaluation over the stored image; a monitor pops and
// compares them as outputs are accepted.
// ---------------------------------------------------------------------------
module tb_sobel_stream_ctrl;
  localparam int W  = 8;
  localparam int H  = 8;
  localparam int EW = $clog2(W*H) + 1;

  // ---------------- clock / reset ----------------
  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [7:0]    threshold = 8'd0;
  logic          busy, done;
  logic [EW-1:0] edge_count;
  logic [1:0]    dbg_state;

  always #5 clk = ~clk;

  sobel_stream_ctrl_if sif ();

  sobel_stream_ctrl #(.IMG_W(W), .IMG_H(H)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .threshold  (threshold),
    .stream     (sif.slave),
    .busy       (busy),
    .done       (done),
    .edge_count (edge_count),
    .dbg_state  (dbg_state)
  );

  // ---------------- scoreboard state ----------------
  logic [0:0] exp_q[$];
  int         errors = 0;
  int         checks = 0;
  int         done_cnt = 0;
  int         exp_edges = 0;
  int         or_mode = 0;   // 0: out_ready always 1, 1: random
  bit         abort = 0;
  bit         prev_done = 0;
  bit         hold_pend = 0;
  logic       hold_val = 1'b0;
  logic [7:0] img [H][W];

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int px(input int r, input int c);
    return int'(img[r][c]);
  endfunction

  function automatic bit ref_edge(input int r, input int c, input int thr);
    int gx, gy;
    gx = (px(r-2,c) + 2*px(r-1,c) + px(r,c)) - (px(r-2,c-2) + 2*px(r-1,c-2) + px(r,c-2));
    gy = (px(r,c-2) + 2*px(r,c-1) + px(r,c)) - (px(r-2,c-2) + 2*px(r-2,c-1) + px(r-2,c));
    if (gx < 0) gx = -gx;
    if (gy < 0) gy = -gy;
    return (gx + gy) > thr;
  endfunction

  task automatic build_expected(input int thr);
    exp_edges = 0;
    for (int r = 2; r < H; r++)
      for (int c = 2; c < W; c++) begin
        bit e;
        e = ref_edge(r, c, thr);
        exp_q.push_back(e);
        if (e) exp_edges++;
      end
  endtask

  function automatic int edge_count_req();
`ifdef SOBEL_EDGE_COUNT_EN
    return exp_edges;
`else
    return 0;
`endif
  endfunction

  // ---------------- image builders ----------------
  task automatic fill_const(input logic [7:0] v);
    for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) img[r][c] = v;
  endtask

  task automatic fill_vstep(input int at, input logic [7:0] a, input logic [7:0] b);
    for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) img[r][c] = (c < at) ? a : b;
  endtask

  task automatic fill_hstep(input int at, input logic [7:0] a, input logic [7:0] b);
    for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) img[r][c] = (r < at) ? a : b;
  endtask

  task automatic fill_rand();
    for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) img[r][c] = 8'($urandom_range(0, 255));
  endtask

  // ---------------- drivers ----------------
  initial begin
    sif.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      sif.out_ready = (or_mode == 0) ? 1'b1 : ($urandom_range(0, 2) != 0);
    end
  end

  task automatic send_pixel(input logic [7:0] p, input bit stall);
    int guard;
    guard = 0;
    if (abort) return;
    if (stall) begin
      while ($urandom_range(0, 3) == 0) begin
        sif.in_valid = 1'b0;
        @(posedge clk);
        #1;
      end
    end
    sif.in_valid = 1'b1;
    sif.in_pixel = p;
    forever begin
      @(negedge clk);
      if (sif.in_ready) break;
      guard++;
      if (guard > 200) begin
        check("in_ready_timeout", 0, 1);
        abort = 1;
        sif.in_valid = 1'b0;
        return;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input logic [7:0] thr);
    @(posedge clk);
    #1;
    threshold = thr;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    threshold = 8'($urandom_range(0, 255));
  endtask

  // glitch_idx >= 0 pulses start (and changes threshold) during that pixel.
  task automatic run_frame(input logic [7:0] thr, input bit stall, input int glitch_idx);
    int d0, guard;
    if (abort) return;
    build_expected(int'(thr));
    or_mode = stall ? 1 : 0;
    d0 = done_cnt;
    pulse_start(thr);
    check("busy_after_start", busy, 1);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) begin
        if (r*W + c == glitch_idx) begin
          start = 1'b1;
          threshold = 8'($urandom_range(0, 255));
        end
        send_pixel(img[r][c], stall);
        start = 1'b0;
      end
    sif.in_valid = 1'b0;
    guard = 0;
    while (done_cnt == d0 && guard < 1000) begin
      @(posedge clk);
      guard++;
    end
    repeat (3) @(posedge clk);
    #1;
    check("done_count", done_cnt - d0, 1);
    check("outputs_left", exp_q.size(), 0);
    check("idle_after_done", int'(dbg_state), 0);
    check("busy_after_done", busy, 0);
    if (done_cnt == d0) begin
      abort = 1;
      exp_q.delete();
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"}, sif.in_ready, 0);
    check({tag, "_out_valid"}, sif.out_valid, 0);
    check({tag, "_out_edge"}, sif.out_edge, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_edge_count"}, int'(edge_count), 0);
    check({tag, "_state"}, int'(dbg_state), 0);
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (!rst_n) begin
      hold_pend = 0;
      prev_done = 0;
    end else begin
      if (hold_pend) begin
        check("hold_valid", sif.out_valid, 1);
        check("hold_edge", sif.out_edge, hold_val);
      end
      hold_pend = 0;
      if (sif.out_valid && sif.out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_output", 1, 0);
        end else begin
          logic [0:0] e;
          e = exp_q.pop_front();
          check("out_edge", sif.out_edge, e);
        end
      end else if (sif.out_valid) begin
        hold_pend = 1;
        hold_val  = sif.out_edge;
      end
      if (prev_done) begin
        check("done_width", done, 0);
        check("edge_count", int'(edge_count), edge_count_req());
      end
      if (done) begin
        done_cnt++;
        check("drained_at_done", exp_q.size(), 0);
      end
      prev_done = done;
    end
  end

  // ---------------- main sequence ----------------
  initial begin
    sif.in_valid = 1'b0;
    sif.in_pixel = 8'd0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    fill_const(8'd100);          run_frame(8'd0,   0, -1);
    fill_vstep(4, 8'd0, 8'd200); run_frame(8'd255, 0, -1);
    fill_vstep(4, 8'd255, 8'd0); run_frame(8'd255, 1, -1);
    fill_vstep(4, 8'd0, 8'd63);  run_frame(8'd252, 0, -1);
    fill_vstep(4, 8'd0, 8'd64);  run_frame(8'd255, 0, -1);
    fill_hstep(4, 8'd0, 8'd255); run_frame(8'd255, 1, -1);
    for (int k = 0; k < 3; k++) begin
      fill_rand();
      run_frame(8'($urandom_range(0, 255)), 1, -1);
    end

    // Reset in the middle of a frame while an output is pending.
    if (!abort) begin
      fill_rand();
      build_expected(128);
      or_mode = 0;
      pulse_start(8'd128);
      for (int i = 0; i < 20; i++) send_pixel(img[i / W][i % W], 0);
      #1;
      check("pre_reset_valid", sif.out_valid, 1);
      #1;
      rst_n = 1'b0;
      sif.in_valid = 1'b0;
      #1;
      check_reset_outputs("async_reset");
      exp_q.delete();
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
    end
    fill_rand(); run_frame(8'($urandom_range(0, 255)), 1, -1);

    // start pulsed mid-frame must be ignored.
    fill_rand(); run_frame(8'($urandom_range(0, 255)), 1, 13);

    repeat (5) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end
endmodule

// File: doc/sobel_stream_ctrl.md
# sobel_stream_ctrl

Streaming controller that sequences the combinational `sobel` edge core over a raster-scan image. It accepts one 8-bit pixel per handshake and keeps two line buffers plus a 3x3 window register. It drives the core's eight neighbour inputs and emits one registered edge bit for every interior pixel, with valid/ready flow control on both sides. It sits between the pixel source (camera/DMA) and the edge-map sink.

## Interface
- `IMG_W`, default 64: image width in pixels, ≥ 3.
- `IMG_H`, default 64: image height in pixels, ≥ 3.
- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `start`  in  1  one-cycle pulse that begins a frame; honoured only in IDLE.
- `threshold`  in  8  edge threshold, sampled on accepted `start`.
- `in_valid`  in  1  pixel valid.
- `in_ready`  out  1  controller accepts pixel this cycle.
- `in_pixel`  in  8  pixel value, raster order, row 0 col 0 first.
- `out_valid`  out  1  `out_edge` valid.
- `out_ready`  in  1  sink accepts output.
- `out_edge`  out  1  1 = edge at the current interior pixel.
- `busy`  out  1  high in RUN and DRAIN.
- `done`  out  1  one-cycle pulse at frame end.
- `edge_count`  out  `$clog2(IMG_W*IMG_H)+1`  edges in the last frame (see Configuration).

## Operation
- States:
  - IDLE: `start` → RUN. Clear `col`, `row` and the window, latch `threshold`.
  - RUN: accept pixels. When the last pixel (row IMG_H-1, col IMG_W-1) is accepted → DRAIN.
  - DRAIN: wait until `out_valid` is 0, or until the final output is accepted. Then pulse `done` and go to IDLE.
- Accepted pixel at (row r, col c):
  - `lb1[c]` is read as pixel (r-1,c). `lb0[c]` is read as (r-2,c).
  - Then `lb0[c]←lb1[c]` and `lb1[c]←in_pixel`.
  - The window shifts left one column. The new right column is {lb0[c], lb1[c], in_pixel} from top to bottom.
- The window maps to core pins row-major: p0 = (r-2,c-2), p1 = (r-2,c-1), p2 = (r-2,c), p3 = (r-1,c-2), p5 = (r-1,c), p6 = (r,c-2), p7 = (r,c-1), p8 = (r,c). The centre pixel is unused.
- A pixel is interior when r ≥ 2 and c ≥ 2. On acceptance of an interior pixel, `out_edge` is registered from the core using the post-shift window, and `out_valid` is set.
- Border pixels produce no output. A frame yields exactly (IMG_W-2)·(IMG_H-2) outputs.
- The core output equals `(|gx|+|gy|) > threshold`, with |g| ≤ 1020 per axis and a 12-bit sum. The controller does not truncate it.
- Column wrap: at c = IMG_W-1, `col←0` and `row←row+1`. The window is not cleared; stale columns are never emitted because the c ≥ 2 rule excludes them.
- `start` outside IDLE is ignored. `threshold` changes mid-frame have no effect.

## Timing
- `in_ready = (state==RUN) && (!out_valid || out_ready)`.
- An accept happens when `in_valid && in_ready`.
- Latency: an interior pixel accepted at cycle N gives `out_valid` = 1 at N+1.
- `out_valid`/`out_edge` hold stable until `out_ready`.
- Output accepted and new interior pixel accepted in the same cycle: `out_valid` stays 1 with the new `out_edge`. Sustained throughput is 1 pixel/cycle.
- Output accepted with no new interior pixel: `out_valid`←0 the next cycle.
- `done` is high for exactly 1 cycle, the cycle the FSM enters IDLE.
- Reset values (also on `rst_n` low mid-frame, which applies immediately and asynchronously):
  - State IDLE; `in_ready`, `out_valid`, `out_edge`, `busy`, `done` = 0; `edge_count` = 0.
  - Counters zero; latched threshold 0.
  - Line buffer contents are don't-care.

## Configuration
- `SOBEL_EDGE_COUNT_EN` defined:
  - An internal counter clears on accepted `start` and increments on every output handshake with `out_edge` = 1.
  - `edge_count` is updated from it on the `done` pulse and holds until the next `done`.
- `SOBEL_EDGE_COUNT_EN` undefined: no counter logic, and `edge_count` is tied to 0.

## Test plan
- IMG_W=IMG_H=4, all pixels 100, threshold 0 → 4 outputs, all `out_edge` = 0, then `done` pulses once.
- 4x4 image with cols 0–1 = 0 and cols 2–3 = 200, threshold 255 → grad 800 at each interior pixel, 4 outputs all 1; with the macro, `edge_count` = 4.
- 4x4 image with cols 0–1 = 255 and cols 2–3 = 0, threshold 255 → grad 1020 at each interior pixel, 4 outputs all 1, showing |g| is used. Repeat with threshold 255 on a single interior step giving grad ≤ 255 → `out_edge` = 0.
- 8x8 random image, random `in_valid`/`out_ready` stalls → output sequence matches the reference model bit for bit, 36 outputs, no output drop or duplicate.
- `rst_n` asserted after 10 pixels → all outputs 0 in the same cycle. A new `start` and full frame then give correct results.
- `start` pulsed during RUN → ignored, frame completes with the expected output count, one `done`.
